// File: rtl/mem_arbiter.sv
// Purpose : shares one single-port memory between the instruction-fetch (I) and data (D) requesters.
// Latency : 1 cycle grant + memory busy cycles + 1 ACK cycle per access.
// Backpres: requesters stall on combinational busywait until their ACK cycle; D wins ties unless
//           I has already lost STARVE_MAX times in a row.
// Ports   : clk/reset (sync, active low); i_* fetch port (read only); d_* data port (read/write);
//           m_* registered memory bus, with m_busywait/m_readdata returned by the memory.
module mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_busywait
);

  typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, ACK_I, ACK_D} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       d_req;
  logic       d_win;
  logic       i_win;

  assign d_req = d_read | d_write;
  // D has priority unless I is waiting and has already been passed over STARVE_MAX times.
  assign d_win = d_req & (~i_read | (starve_cnt < STARVE_LIM));
  assign i_win = ~d_win & i_read;

  // A requester is released only in its own ACK cycle; it samples readdata on the edge ending it.
  assign i_busywait = i_read & (state != ACK_I);
  assign d_busywait = d_req  & (state != ACK_D);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_address   <= '0;
      m_writedata <= '0;
      i_readdata  <= '0;
      d_readdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // D can only win against a waiting I while the count is below the limit,
          // so the increment never overshoots the saturation value.
          if (i_read && d_win) begin
            starve_cnt <= starve_cnt + 4'd1;
          end else begin
            starve_cnt <= '0;
          end

          if (d_win) begin
            m_address   <= d_address;
            m_writedata <= d_writedata;
            m_write     <= d_write;
            // A combined read+write request performs only the write.
            m_read      <= d_read & ~d_write;
            state       <= SERVE_D;
          end else if (i_win) begin
            m_address <= i_address;
            m_read    <= 1'b1;
            state     <= SERVE_I;
          end
        end

        SERVE_I: begin
          if (!m_busywait) begin
            m_read     <= 1'b0;
            m_write    <= 1'b0;
            i_readdata <= m_readdata;
            state      <= ACK_I;
          end
        end

        SERVE_D: begin
          if (!m_busywait) begin
            if (m_read) begin
              d_readdata <= m_readdata;
            end
            m_read  <= 1'b0;
            m_write <= 1'b0;
            state   <= ACK_D;
          end
        end

        ACK_I, ACK_D: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int STARVE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_read;
  logic [7:0]  i_address;
  logic [31:0] i_readdata;
  logic        i_busywait;
  logic        d_read;
  logic        d_write;
  logic [7:0]  d_address;
  logic [31:0] d_writedata;
  logic [31:0] d_readdata;
  logic        d_busywait;
  logic        m_read;
  logic        m_write;
  logic [7:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        m_busywait;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .m_busywait(m_busywait)
  );

  always #5 clk = ~clk;

  // Contents of never-written locations: a fixed pattern derived from the address.
  function automatic logic [31:0] init_word(input logic [7:0] a);
    return {a, a ^ 8'h3c, ~a, a + 8'h71};
  endfunction

  // ---------------- memory: busy for mem_lat cycles, then one final cycle ----------------
  logic [31:0] mem   [256];
  bit          wflag [256];
  int          mcnt = 0;
  int          mem_lat = 1;

  assign m_busywait = (m_read | m_write) && (mcnt < mem_lat);
  assign m_readdata = wflag[m_address] ? mem[m_address] : init_word(m_address);

  always @(posedge clk) begin
    if ((m_read | m_write) && (mcnt < mem_lat)) mcnt <= mcnt + 1;
    else mcnt <= 0;
    if (m_write && !m_busywait) begin
      mem[m_address]   <= m_writedata;
      wflag[m_address] <= 1'b1;
    end
  end

  // ---------------- reference model ----------------
  // The arbiter is modelled as "occupied for mem_lat+2 edges after a grant": strobes are up
  // while occ>=2, the access completes on the edge where occ==2, and occ==1 is the ACK cycle.
  int          occ = 0;
  int          scnt = 0;
  bit          who_d = 1'b0;
  bit          op_rd = 1'b0;
  logic [7:0]  op_addr = '0;
  logic [31:0] op_data = '0;
  logic [31:0] e_ird = '0;
  logic [31:0] e_drd = '0;
  logic [31:0] smem  [256];
  bit          sflag [256];

  function automatic logic [31:0] shadow_rd(input logic [7:0] a);
    return sflag[a] ? smem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      occ   <= 0;
      scnt  <= 0;
      e_ird <= '0;
      e_drd <= '0;
    end else if (occ == 0) begin
      if ((d_read | d_write) && (!i_read || scnt < STARVE)) begin
        who_d   <= 1'b1;
        op_rd   <= !d_write;
        op_addr <= d_address;
        op_data <= d_writedata;
        occ     <= mem_lat + 2;
        scnt    <= i_read ? ((scnt + 1 > STARVE) ? STARVE : scnt + 1) : 0;
      end else if (i_read) begin
        who_d   <= 1'b0;
        op_rd   <= 1'b1;
        op_addr <= i_address;
        occ     <= mem_lat + 2;
        scnt    <= 0;
      end else begin
        scnt <= 0;
      end
    end else begin
      if (occ == 2) begin
        if (!op_rd) begin
          smem[op_addr]  <= op_data;
          sflag[op_addr] <= 1'b1;
        end else if (who_d) begin
          e_drd <= shadow_rd(op_addr);
        end else begin
          e_ird <= shadow_rd(op_addr);
        end
      end
      occ <= occ - 1;
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic d_access(input bit rd, input bit wr, input logic [7:0] a,
                          input logic [31:0] wd, output bit ok);
    ok = 1'b0;
    d_read = rd; d_write = wr; d_address = a; d_writedata = wd;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!d_busywait) begin
        ok = 1'b1;
        d_read = 1'b0; d_write = 1'b0;
        break;
      end
    end
    d_read = 1'b0; d_write = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; i_read = 1'b1; i_address = 8'h00;
    d_read = 1'b0; d_write = 1'b0; d_address = 8'h00; d_writedata = '0;
    repeat (2) @(negedge clk);
    checks++; if ({m_read, m_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b exp 00", {m_read, m_write}); end
    checks++; if (m_address !== 8'h00) begin errors++; $display("FAIL reset_m_address got %h exp 00", m_address); end
    checks++; if (m_writedata !== 32'h0) begin errors++; $display("FAIL reset_m_writedata got %h exp 0", m_writedata); end
    checks++; if (i_readdata !== 32'h0) begin errors++; $display("FAIL reset_i_readdata got %h exp 0", i_readdata); end
    checks++; if (d_readdata !== 32'h0) begin errors++; $display("FAIL reset_d_readdata got %h exp 0", d_readdata); end
    checks++; if ({i_busywait, d_busywait} !== 2'b10) begin errors++; $display("FAIL reset_busywait got %b exp 10", {i_busywait, d_busywait}); end
    d_write = 1'b1; i_read = 1'b0;
    #1;
    checks++; if ({i_busywait, d_busywait} !== 2'b01) begin errors++; $display("FAIL reset_busywait2 got %b exp 01", {i_busywait, d_busywait}); end
    @(negedge clk);
    d_write = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fetch();
    bit ok;
    int rd_cyc = 0;
    int low_cyc = 0;
    int bad_addr = 0;
    mem_lat = 1;
    d_access(1'b0, 1'b1, 8'h04, 32'hDEADBEEF, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fetch_preload_ack got %b exp 1", ok); end
    repeat (2) @(negedge clk);
    mem_lat = 3;
    i_read = 1'b1; i_address = 8'h04;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (m_read) begin
        rd_cyc++;
        if (m_address !== 8'h04) bad_addr++;
      end
      if (i_read && !i_busywait) begin
        low_cyc++;
        checks++; if (i_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_data_at_ack got %h exp deadbeef", i_readdata); end
        i_read = 1'b0;
      end
    end
    i_read = 1'b0;
    checks++; if (rd_cyc != 4) begin errors++; $display("FAIL fetch_m_read_cycles got %0d exp 4", rd_cyc); end
    checks++; if (low_cyc != 1) begin errors++; $display("FAIL fetch_busywait_low got %0d exp 1", low_cyc); end
    checks++; if (bad_addr != 0) begin errors++; $display("FAIL fetch_m_address wrong in %0d cycles exp 0", bad_addr); end
    checks++; if (i_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_data_held got %h exp deadbeef", i_readdata); end
  endtask

  task automatic test_collide();
    string       order = "";
    bit          prev = 1'b0;
    int          overlap = 0;
    int          bad_wd = 0;
    logic [31:0] got_i = '0;
    mem_lat = 2;
    i_read = 1'b1; i_address = 8'h20;
    d_write = 1'b1; d_address = 8'h10; d_writedata = 32'h55;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (m_read && m_write) overlap++;
      if ((m_read | m_write) && !prev) begin
        if (m_write && m_address == 8'h10) order = {order, "W"};
        else if (m_read && m_address == 8'h20) order = {order, "R"};
        else order = {order, "?"};
      end
      if (m_write && m_writedata !== 32'h55) bad_wd++;
      prev = m_read | m_write;
      if (d_write && !d_busywait) d_write = 1'b0;
      if (i_read && !i_busywait) begin got_i = i_readdata; i_read = 1'b0; end
    end
    i_read = 1'b0; d_write = 1'b0;
    checks++; if (order != "WR") begin errors++; $display("FAIL collide_order got %s exp WR", order); end
    checks++; if (overlap != 0) begin errors++; $display("FAIL collide_overlap got %0d exp 0", overlap); end
    checks++; if (bad_wd != 0) begin errors++; $display("FAIL collide_writedata wrong in %0d cycles exp 0", bad_wd); end
    checks++; if (got_i !== init_word(8'h20)) begin errors++; $display("FAIL collide_fetch_data got %h exp %h", got_i, init_word(8'h20)); end
    checks++; if (!wflag[8'h10] || mem[8'h10] !== 32'h55) begin errors++; $display("FAIL collide_mem_write got %h exp 55", mem[8'h10]); end
  endtask

  task automatic test_starve();
    string seq = "";
    bit    prev = 1'b0;
    mem_lat = 1;
    i_read = 1'b1; i_address = 8'h30;
    d_read = 1'b1; d_address = 8'h40;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if ((m_read | m_write) && !prev && seq.len() < 6) begin
        seq = {seq, (m_address[7:4] == 4'h4) ? "D" : "I"};
        if (seq.len() == 6) begin i_read = 1'b0; d_read = 1'b0; end
      end
      prev = m_read | m_write;
      if (d_read && !d_busywait) d_address = d_address + 8'd1;
      if (i_read && !i_busywait) i_address = i_address + 8'd1;
    end
    i_read = 1'b0; d_read = 1'b0;
    checks++; if (seq != "DDIDDI") begin errors++; $display("FAIL starve_grant_order got %s exp DDIDDI", seq); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen = 1'b0;
    mem_lat = 1;
    d_access(1'b1, 1'b0, 8'h48, '0, ok);
    checks++; if (d_readdata !== init_word(8'h48)) begin errors++; $display("FAIL rstmid_pre_read got %h exp %h", d_readdata, init_word(8'h48)); end
    @(negedge clk);
    mem_lat = 4;
    d_read = 1'b1; d_address = 8'h50;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (m_read) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_no_grant got 0 exp 1"); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({m_read, m_write} !== 2'b00) begin errors++; $display("FAIL rstmid_strobes got %b exp 00", {m_read, m_write}); end
    checks++; if (d_readdata !== 32'h0) begin errors++; $display("FAIL rstmid_d_readdata got %h exp 0", d_readdata); end
    checks++; if (m_address !== 8'h00) begin errors++; $display("FAIL rstmid_m_address got %h exp 00", m_address); end
    reset = 1'b1; d_read = 1'b0;
    @(negedge clk);
    mem_lat = 2;
    d_access(1'b1, 1'b0, 8'h51, '0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_fresh_ack got %b exp 1", ok); end
    checks++; if (d_readdata !== init_word(8'h51)) begin errors++; $display("FAIL rstmid_fresh_data got %h exp %h", d_readdata, init_word(8'h51)); end
  endtask

  task automatic test_read_write_both();
    logic [31:0] old_rd;
    bit saw_rd = 1'b0;
    bit saw_wr = 1'b0;
    bit acked  = 1'b0;
    mem_lat = 2;
    @(negedge clk);
    old_rd = d_readdata;
    d_read = 1'b1; d_write = 1'b1; d_address = 8'h60; d_writedata = 32'hA5;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_read) saw_rd = 1'b1;
      if (m_write) saw_wr = 1'b1;
      if ((d_read | d_write) && !d_busywait) begin acked = 1'b1; d_read = 1'b0; d_write = 1'b0; end
    end
    checks++; if (!acked) begin errors++; $display("FAIL both_ack got 0 exp 1"); end
    checks++; if ({saw_rd, saw_wr} !== 2'b01) begin errors++; $display("FAIL both_strobes got rd/wr %b exp 01", {saw_rd, saw_wr}); end
    checks++; if (d_readdata !== old_rd) begin errors++; $display("FAIL both_readdata got %h exp %h", d_readdata, old_rd); end
    checks++; if (!wflag[8'h60] || mem[8'h60] !== 32'hA5) begin errors++; $display("FAIL both_mem got %h exp a5", mem[8'h60]); end
  endtask

  task automatic test_random(input int lat, input int ncyc);
    logic       strobe;
    logic [1:0] exp_bw;
    int         bad = 0;
    mem_lat = lat;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      strobe = (occ >= 2);
      checks++; if ({m_read, m_write} !== {strobe && op_rd, strobe && !op_rd}) begin errors++; bad++;
        $display("FAIL rnd_strobes t=%0t got %b exp %b", $time, {m_read, m_write}, {strobe && op_rd, strobe && !op_rd}); end
      if (strobe) begin
        checks++; if (m_address !== op_addr) begin errors++; bad++; $display("FAIL rnd_m_address t=%0t got %h exp %h", $time, m_address, op_addr); end
      end
      if (strobe && !op_rd) begin
        checks++; if (m_writedata !== op_data) begin errors++; bad++; $display("FAIL rnd_m_writedata t=%0t got %h exp %h", $time, m_writedata, op_data); end
      end
      checks++; if (i_readdata !== e_ird) begin errors++; bad++; $display("FAIL rnd_i_readdata t=%0t got %h exp %h", $time, i_readdata, e_ird); end
      checks++; if (d_readdata !== e_drd) begin errors++; bad++; $display("FAIL rnd_d_readdata t=%0t got %h exp %h", $time, d_readdata, e_drd); end
      exp_bw = {i_read && !(occ == 1 && !who_d), (d_read | d_write) && !(occ == 1 && who_d)};
      checks++; if ({i_busywait, d_busywait} !== exp_bw) begin errors++; bad++; $display("FAIL rnd_busywait t=%0t got %b exp %b", $time, {i_busywait, d_busywait}, exp_bw); end
      if (bad > 20) begin
        $display("FAIL rnd_abort too many mismatches got %0d exp 0", bad);
        break;
      end

      if (i_read) begin
        if (!i_busywait) begin
          if ($urandom_range(0, 1) == 1) i_address = 8'($urandom);
          else i_read = 1'b0;
        end else if ($urandom_range(0, 31) == 0) begin
          i_read = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        i_read = 1'b1; i_address = 8'($urandom);
      end

      if (d_read | d_write) begin
        if (!d_busywait || $urandom_range(0, 31) == 0) begin
          d_read = 1'b0; d_write = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    begin d_read = 1'b1; d_write = 1'b0; end
          2:       begin d_read = 1'b0; d_write = 1'b1; end
          default: begin d_read = 1'b1; d_write = 1'b1; end
        endcase
        d_address = 8'($urandom);
        d_writedata = $urandom;
      end
    end
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0;
    test_reset();
    test_fetch();
    test_collide();
    test_starve();
    test_reset_mid();
    test_read_write_both();
    test_random(1, 600);
    test_random(3, 600);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
